// File: rtl/data_sync.sv
// Receives a data word from a foreign clock domain: synchronizes the valid strobe,
// captures the word on its rising edge and holds it until the consumer acknowledges.
module data_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_data_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_data_valid,
    input  logic             out_data_retrieved,
    output logic             overflow
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   overflow_q, overflow_d;
    logic                   cap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    // Bit 0 is the metastability-exposed stage; only the last stage feeds logic.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_data_valid};
        hist_d = sync_q[SYNC_STAGES-1];
        cap    = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        unique case (state_q)
            EMPTY: begin
                if (cap) begin
                    data_d  = in_data;
                    state_d = FULL;
                end
            end
            FULL: begin
                // A retrieve in the capture cycle frees the slot for the new word.
                if (cap && out_data_retrieved) begin
                    data_d = in_data;
                end else if (cap) begin
                    overflow_d = 1'b1;
                end else if (out_data_retrieved) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign out_data       = data_q;
    assign out_data_valid = (state_q == FULL);
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_data_sync.sv
// Bench for data_sync: directed scenarios followed by randomized strobes, all checked
// every cycle against a behavioural model built on the sampled-valid history.
module tb_data_sync;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_data_valid = 1'b0;
    logic [W-1:0] out_data;
    logic         out_data_valid;
    logic         out_data_retrieved = 1'b0;
    logic         overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    bit           hist[$];
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_data  = '0;
    logic         exp_ovf   = 1'b0;

    data_sync #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_data           (in_data),
        .in_data_valid     (in_data_valid),
        .out_data          (out_data),
        .out_data_valid    (out_data_valid),
        .out_data_retrieved(out_data_retrieved),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit sample_at(input int i);
        if (i < 0 || i >= hist.size()) return 1'b0;
        return hist[i];
    endfunction

    // One clock edge: the model decides what that edge must do from the inputs held
    // across it, then all outputs are compared shortly after the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic rst = 1'b0);
        bit rise;
        int n;
        in_data_valid      = v;
        in_data            = d;
        out_data_retrieved = r;
        reset              = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            hist.delete();
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_ovf   = 1'b0;
        end else begin
            // A capture happens S edges after the first edge that saw the valid high.
            n    = hist.size();
            rise = sample_at(n - S) && !sample_at(n - S - 1);
            if (rise) begin
                if (!exp_valid || r) begin
                    exp_data  = d;
                    exp_valid = 1'b1;
                end else begin
                    exp_ovf = 1'b1;
                end
            end else if (exp_valid && r) begin
                exp_valid = 1'b0;
            end
            hist.push_back(v);
        end
        check("valid", 32'(out_data_valid), 32'(exp_valid));
        check("data", 32'(out_data), 32'(exp_data));
        check("overflow", 32'(overflow), 32'(exp_ovf));
    endtask

    // Data set one cycle early, valid held hi cycles, then low lo cycles.
    // ret_idx selects which high cycle carries a retrieve (-1 for none).
    task automatic strobe(input logic [W-1:0] d, input int hi, input int lo, input int ret_idx = -1);
        step(1'b0, d, 1'b0);
        for (int i = 0; i < hi; i++) step(1'b1, d, (i == ret_idx));
        for (int i = 0; i < lo; i++) step(1'b0, d, 1'b0);
    endtask

    initial begin
        int hi, lo;
        logic [W-1:0] d;

        // reset state
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("rst_valid", 32'(out_data_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // basic capture: nothing after two sampling edges, valid after the third
        step(1'b0, 4'd1, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        check("cap_early", 32'(out_data_valid), 32'd0);
        step(1'b1, 4'd1, 1'b0);
        check("cap_valid", 32'(out_data_valid), 32'd1);
        check("cap_data", 32'(out_data), 32'd1);
        step(1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd1, 1'b0);
        check("cap_ovf", 32'(overflow), 32'd0);

        // retrieve, then a second ignored retrieve
        step(1'b0, 4'd1, 1'b1);
        check("ret_valid", 32'(out_data_valid), 32'd0);
        check("ret_data", 32'(out_data), 32'd1);
        step(1'b0, 4'd1, 1'b0);
        step(1'b0, 4'd1, 1'b1);
        check("ret2_valid", 32'(out_data_valid), 32'd0);

        // drop while full
        strobe(4'd1, 4, 3);
        strobe(4'd2, 4, 3);
        check("drop_data", 32'(out_data), 32'd1);
        check("drop_ovf", 32'(overflow), 32'd1);
        step(1'b0, 4'd2, 1'b1);
        strobe(4'd3, 4, 3);
        check("after_drop_data", 32'(out_data), 32'd3);
        check("after_drop_valid", 32'(out_data_valid), 32'd1);
        check("after_drop_ovf", 32'(overflow), 32'd1);

        // reset while full with overflow set
        step(1'b0, 4'd3, 1'b0, 1'b1);
        check("rstfull_data", 32'(out_data), 32'd0);
        check("rstfull_valid", 32'(out_data_valid), 32'd0);
        check("rstfull_ovf", 32'(overflow), 32'd0);

        // simultaneous capture and retrieve (capture lands on high cycle index S)
        strobe(4'd1, 4, 3);
        strobe(4'd5, 4, 3, S);
        check("sim_data", 32'(out_data), 32'd5);
        check("sim_valid", 32'(out_data_valid), 32'd1);
        check("sim_ovf", 32'(overflow), 32'd0);

        // delayed retrieve
        step(1'b0, 4'd5, 1'b1);
        strobe(4'd3, 4, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd3, 1'b0);
            check("delay_hold", 32'(out_data_valid), 32'd1);
        end
        step(1'b0, 4'd3, 1'b1);
        check("delay_clear", 32'(out_data_valid), 32'd0);
        check("delay_data", 32'(out_data), 32'd3);

        // reset during synchronization discards the strobe
        step(1'b0, 4'd7, 1'b0);
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd7, 1'b0, 1'b1);
        step(1'b0, 4'd7, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd7, 1'b0);
        check("rstsync_valid", 32'(out_data_valid), 32'd0);
        check("rstsync_data", 32'(out_data), 32'd0);

        // valid still high at reset release refills the chain: one capture
        step(1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd9, 1'b0, 1'b1);
        step(1'b1, 4'd9, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd9, 1'b0);
        check("rstrefill_valid", 32'(out_data_valid), 32'd1);
        check("rstrefill_data", 32'(out_data), 32'd9);
        for (int i = 0; i < 4; i++) step(1'b1, 4'd9, 1'b0);
        check("one_per_level_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd9, 1'b0);

        // randomized strobes, retrieves and occasional resets
        for (int k = 0; k < 150; k++) begin
            d  = W'($urandom);
            hi = $urandom_range(S + 1, S + 4);
            lo = $urandom_range(S + 1, S + 4);
            step(1'b0, d, ($urandom_range(0, 3) == 0));
            for (int i = 0; i < hi; i++) step(1'b1, d, ($urandom_range(0, 3) == 0));
            for (int i = 0; i < lo; i++) step(1'b0, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
